stim_vec_player: RTL and testbench
==================================

# stim_vec_player

Programmable stimulus sequencer that drives the 4-bit input vector (i1..i4) of the downstream sequence-detector FSM. A small step table is written over a simple write port, holding one vector and one dwell count per step. On `start` the block plays steps 0..len-1 in order, holding each vector for a programmed number of cycles, then returns the vector to zero and pulses `done`. It sits directly upstream of the detector in bench and bring-up builds.

## Interface
- `DEPTH`, 16, number of table entries (power of two, ≥2)
- `DW`, 12, dwell-count width
- `AW`, $clog2(DEPTH), table address width (derived)

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `wr_en`  in  1  table write strobe
- `wr_addr`  in  AW  table entry to write
- `wr_vec`  in  4  vector for entry; bit0=i1, bit1=i2, bit2=i3, bit3=i4
- `wr_dwell`  in  DW  dwell for entry; vector held dwell+1 cycles
- `len`  in  AW+1  number of steps to play, sampled with `start`
- `start`  in  1  begin playback (IDLE only)
- `abort`  in  1  stop playback immediately, no `done`
- `vec_out`  out  4  vector to detector {i4,i3,i2,i1}
- `step_idx`  out  AW  index of step currently driven
- `step_strobe`  out  1  1-cycle pulse on the first cycle of each step
- `busy`  out  1  high while in PLAY
- `done`  out  1  1-cycle pulse after last step completes

## Operation
- States: IDLE, PLAY.
- Reset: state IDLE; `vec_out`=0, `step_idx`=0, `step_strobe`=0, `busy`=0, `done`=0, dwell counter 0, latched length 0. Table contents are not cleared.
- Table writes are accepted only in IDLE. `wr_en` while `busy` is ignored.
- IDLE, with `start`=1, `abort`=0, and `len`≠0:
  - Latch min(`len`, DEPTH).
  - Go to PLAY with step 0 applied: `vec_out`=table[0].vec, `step_idx`=0, `step_strobe`=1, counter=table[0].dwell.
- IDLE, with `start` and `len`=0: no playback; `done` pulses on the next cycle.
- PLAY, counter>0: decrement the counter and hold the vector.
- PLAY, counter=0 and step<len-1: advance to step+1. Load its vector and dwell, and pulse `step_strobe`.
- PLAY, counter=0 and last step: go to IDLE with `vec_out`=0, `busy`=0, `done`=1 for one cycle.
- `start` during PLAY is ignored.
- `abort` in PLAY: next cycle IDLE, `vec_out`=0, `step_idx`=0, no `done`. `abort` has priority over `start` and over step advance.
- Reset mid-playback behaves exactly like the reset state above.

## Timing
- `start` sampled at edge T: the step-0 vector is visible from T+1 (latency 1).
- Step k occupies exactly dwell_k+1 cycles. There are no gap cycles between steps.
- `busy` is high for Σ(dwell_k+1) cycles.
- `done` is asserted in the first cycle after the last step, coincident with `vec_out`=0.
- The earliest next `start` is sampled in the `done` cycle.
- Maximum dwell (2^DW−1) holds a step for 2^DW cycles; the counter does not wrap.

## Configuration
- Macro: `STIM_VEC_PLAYER_LOOP_EN`.
- Defined:
  - Adds input port `loop` (1 bit), sampled with `start`.
  - If latched `loop`=1, after the last step the block wraps to step 0, pulses `step_strobe`, keeps `busy` high, and never asserts `done`. Only `abort` or `reset` ends playback.
- Undefined: no `loop` port; playback is always single-shot.

## Structure
- Shared package `stim_pkg`:
  - `stim_step_t` packed struct {vec[3:0], dwell[DW-1:0]}
  - `stim_state_e` {IDLE, PLAY}
  - bit-position constants for i1..i4 within `vec`
- One sub-module, `stim_step_ram`: DEPTH × (4+DW) register array with one write port and one asynchronous read port. Reads are combinational so step advance needs no extra cycle.

## Test plan
- Write {0x4,d1},{0x9,d0},{0x2,d2}, start with len=3 → `vec_out` 4,4,9,2,2,2 then 0 with `done`=1. `busy` high for 6 cycles. `step_strobe` at cycles 1, 3, 4.
- Start with len=0 → `busy` stays 0, `done` pulses once at T+1, `vec_out` stays 0.
- Abort during step 1 of the 3-step program → next cycle `vec_out`=0, `busy`=0, `step_idx`=0, `done` never asserted.
- During playback, write entry 0 with 0xF and pulse `start` → `start` ignored. A replay after `done` still shows vector 0x4, because the write was dropped.
- Program the detector's 12-vector sequence: 4 (i3), then 9 (i1,i4), then 0, and so on, with dwell 0; start with len=20 → clamped to 16 steps. Detector reaches its final state.
- With `STIM_VEC_PLAYER_LOOP_EN` defined, loop=1, 2 steps {0x1,d0},{0x8,d0} → `vec_out` toggles 1,8,1,8… with no `done`. `abort` stops it in 1 cycle.

Source files
------------

// File: rtl/stim_pkg.sv
// -----------------------------------------------------------------------------
// stim_pkg
// Shared definitions for the stimulus vector player.
//   - STIM_DEPTH / STIM_DW : default table depth and dwell-count width
//   - stim_step_t          : one step-table entry {vec, dwell}
//   - stim_state_e         : player FSM states
//   - I1_BIT..I4_BIT       : position of each detector input within vec
// -----------------------------------------------------------------------------
package stim_pkg;

    localparam int STIM_DEPTH = 16;
    localparam int STIM_DW    = 12;
    localparam int VEC_W      = 4;

    // Detector input positions inside the 4-bit vector {i4,i3,i2,i1}.
    localparam int I1_BIT = 0;
    localparam int I2_BIT = 1;
    localparam int I3_BIT = 2;
    localparam int I4_BIT = 3;

    // Table entry layout at the default dwell width; the RAM word places
    // vec above dwell in exactly this order for any DW.
    typedef struct packed {
        logic [VEC_W-1:0]   vec;
        logic [STIM_DW-1:0] dwell;
    } stim_step_t;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } stim_state_e;

endpackage

// File: rtl/stim_step_ram.sv
// -----------------------------------------------------------------------------
// stim_step_ram
// DEPTH x (4+DW) step table: one synchronous write port, one combinational
// read port so the player can load the next step in the same cycle it
// decides to advance.
// Ports:
//   clk      in   clock
//   we       in   write enable
//   wr_addr  in   AW     write address
//   wr_data  in   4+DW   {vec, dwell}
//   rd_addr  in   AW     read address
//   rd_data  out  4+DW   {vec, dwell} at rd_addr
// -----------------------------------------------------------------------------
module stim_step_ram #(
    parameter  int DEPTH = 16,
    parameter  int DW    = 12,
    localparam int AW    = $clog2(DEPTH),
    localparam int WW    = 4 + DW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [WW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [WW-1:0] rd_data
);

    logic [WW-1:0] mem_q [DEPTH];

    // NOTE: the table has no reset; its contents survive reset and are only
    // ever changed by explicit writes, which also keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/stim_vec_player.sv
// -----------------------------------------------------------------------------
// stim_vec_player
// Plays a programmed table of 4-bit vectors into the sequence detector.
// Each step holds its vector for dwell+1 cycles; after the last step the
// vector returns to zero and done pulses for one cycle.
// Optional feature macro: STIM_VEC_PLAYER_LOOP_EN adds a 'loop' input; when
// latched high with start, playback wraps to step 0 forever (until abort).
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   wr_en/addr/vec/dwell table write port (accepted in IDLE only)
//   len                  steps to play, sampled with start (clamped to DEPTH)
//   start, abort         begin playback / stop immediately without done
//   loop                 (macro only) repeat playback forever
//   vec_out              {i4,i3,i2,i1} to the detector
//   step_idx             step currently driven
//   step_strobe          pulse on the first cycle of each step
//   busy, done           playing / one-cycle completion pulse
// -----------------------------------------------------------------------------
module stim_vec_player
    import stim_pkg::*;
#(
    parameter  int DEPTH = STIM_DEPTH,
    parameter  int DW    = STIM_DW,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [3:0]    wr_vec,
    input  logic [DW-1:0] wr_dwell,
    input  logic [AW:0]   len,
    input  logic          start,
    input  logic          abort,
`ifdef STIM_VEC_PLAYER_LOOP_EN
    input  logic          loop,
`endif
    output logic [3:0]    vec_out,
    output logic [AW-1:0] step_idx,
    output logic          step_strobe,
    output logic          busy,
    output logic          done
);

    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

    stim_state_e   state_q;
    logic [3:0]    vec_q;
    logic [AW-1:0] step_q;
    logic          strobe_q;
    logic          busy_q;
    logic          done_q;
    logic [DW-1:0] cnt_q;
    logic [AW:0]   len_q;

    logic [AW-1:0] rd_addr;
    logic [DW+3:0] rd_data;
    logic [3:0]    rd_vec;
    logic [DW-1:0] rd_dwell;
    logic          last_step;
    logic          start_ok;
    logic          loop_en;
    logic [AW:0]   len_d;

    assign start_ok  = (state_q == IDLE) && start && !abort;
    assign len_d     = (len > DEPTH_L) ? DEPTH_L : len;
    assign last_step = ({1'b0, step_q} == (len_q - 1'b1));

    // In IDLE the read port points at step 0 so start can load it directly;
    // in PLAY it looks one step ahead, wrapping to 0 after the last step.
    assign rd_addr  = (state_q == PLAY && !last_step) ? step_q + 1'b1 : '0;
    assign rd_vec   = rd_data[DW +: 4];
    assign rd_dwell = rd_data[DW-1:0];

    stim_step_ram #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_ram (
        .clk     (clk),
        .we      (wr_en && (state_q == IDLE)),
        .wr_addr (wr_addr),
        .wr_data ({wr_vec, wr_dwell}),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

`ifdef STIM_VEC_PLAYER_LOOP_EN
    logic loop_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            loop_q <= 1'b0;
        end else if (start_ok) begin
            loop_q <= loop;
        end
    end

    assign loop_en = loop_q;
`else
    assign loop_en = 1'b0;
`endif

    // NOTE: all state and registered outputs update with non-blocking
    // assignments so every branch sees the pre-edge values consistently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            step_q   <= '0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            len_q    <= '0;
        end else begin
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        if (len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q  <= PLAY;
                            len_q    <= len_d;
                            vec_q    <= rd_vec;
                            step_q   <= '0;
                            strobe_q <= 1'b1;
                            busy_q   <= 1'b1;
                            cnt_q    <= rd_dwell;
                        end
                    end
                end
                PLAY: begin
                    if (abort) begin
                        state_q <= IDLE;
                        vec_q   <= '0;
                        step_q  <= '0;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (!last_step || loop_en) begin
                        // rd_addr already points at the next (or wrapped) step.
                        step_q   <= last_step ? '0 : step_q + 1'b1;
                        vec_q    <= rd_vec;
                        cnt_q    <= rd_dwell;
                        strobe_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        vec_q   <= '0;
                        step_q  <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign vec_out     = vec_q;
    assign step_idx    = step_q;
    assign step_strobe = strobe_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_stim_vec_player.sv
// -----------------------------------------------------------------------------
// tb_stim_vec_player
// Scoreboard bench: the driver expands each playback request into the
// cycle-by-cycle output trace implied by the step table and pushes it into
// a queue; a negedge monitor pops and compares whenever busy or done is up,
// and checks that the vector rests at zero otherwise.
// -----------------------------------------------------------------------------
module tb_stim_vec_player;
    import stim_pkg::*;

    localparam int DEPTH = STIM_DEPTH;
    localparam int DW    = STIM_DW;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [3:0]    wr_vec = '0;
    logic [DW-1:0] wr_dwell = '0;
    logic [AW:0]   len = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
`ifdef STIM_VEC_PLAYER_LOOP_EN
    logic          loop = 1'b0;
`endif
    logic [3:0]    vec_out;
    logic [AW-1:0] step_idx;
    logic          step_strobe;
    logic          busy;
    logic          done;

    stim_vec_player #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_vec      (wr_vec),
        .wr_dwell    (wr_dwell),
        .len         (len),
        .start       (start),
        .abort       (abort),
`ifdef STIM_VEC_PLAYER_LOOP_EN
        .loop        (loop),
`endif
        .vec_out     (vec_out),
        .step_idx    (step_idx),
        .step_strobe (step_strobe),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] vec;
        int         idx;
        bit         strobe;
        bit         busy;
        bit         done;
        bit         idx_chk;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en   = 1'b0;

    // Reference table: what the bench believes the step table holds.
    logic [3:0] m_vec   [DEPTH];
    int         m_dwell [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every busy/done cycle must match the next scoreboard entry.
    exp_t e;
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy === 1'b1 || done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {30'd0, busy, done}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("vec_out", {28'd0, vec_out}, {28'd0, e.vec});
                    check("step_strobe", {31'd0, step_strobe}, {31'd0, e.strobe});
                    check("busy", {31'd0, busy}, {31'd0, e.busy});
                    check("done", {31'd0, done}, {31'd0, e.done});
                    if (e.idx_chk) check("step_idx", 32'(step_idx), 32'(e.idx));
                end
            end else begin
                check("idle_vec", {28'd0, vec_out}, 32'd0);
                check("idle_strobe", {31'd0, step_strobe}, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int a, input logic [3:0] v, input int d, input bit taken);
        wr_en    = 1'b1;
        wr_addr  = AW'(a);
        wr_vec   = v;
        wr_dwell = DW'(d);
        tick();
        wr_en = 1'b0;
        if (taken) begin
            m_vec[a]   = v;
            m_dwell[a] = d;
        end
    endtask

    // Expand the table into the expected trace, then issue start.
    task automatic start_play(input int l);
        int   n;
        exp_t x;
        n = (l > DEPTH) ? DEPTH : l;
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c <= m_dwell[k]; c++) begin
                x = '{vec: m_vec[k], idx: k, strobe: (c == 0), busy: 1'b1, done: 1'b0, idx_chk: 1'b1};
                exp_q.push_back(x);
            end
        end
        x = '{vec: 4'h0, idx: 0, strobe: 1'b0, busy: 1'b0, done: 1'b1, idx_chk: 1'b0};
        exp_q.push_back(x);
        start = 1'b1;
        len   = (AW+1)'(l);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 10000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        tick();
    endtask

    // Abort so that exactly k busy cycles are seen after the start edge.
    task automatic abort_after(input int k);
        repeat (k - 1) @(posedge clk);
        #1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_q.delete();
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_vec", {28'd0, vec_out}, 32'd0);
        check("abort_idx", 32'(step_idx), 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        repeat (3) tick();
    endtask

    task automatic load_three_step();
        write_entry(0, 4'h4, 1, 1'b1);
        write_entry(1, 4'h9, 0, 1'b1);
        write_entry(2, 4'h2, 2, 1'b1);
    endtask

`ifdef STIM_VEC_PLAYER_LOOP_EN
    task automatic loop_test();
        exp_t x;
        write_entry(0, 4'h1, 0, 1'b1);
        write_entry(1, 4'h8, 0, 1'b1);
        for (int c = 0; c < 7; c++) begin
            x = '{vec: (c % 2 == 1) ? 4'h8 : 4'h1, idx: c % 2, strobe: 1'b1, busy: 1'b1,
                  done: 1'b0, idx_chk: 1'b1};
            exp_q.push_back(x);
        end
        loop  = 1'b1;
        start = 1'b1;
        len   = (AW+1)'(2);
        tick();
        start = 1'b0;
        loop  = 1'b0;
        abort_after(7);
    endtask
`endif

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_vec[i]   = 4'h0;
            m_dwell[i] = 0;
        end

        // Reset state.
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_vec", {28'd0, vec_out}, 32'd0);
        check("rst_idx", 32'(step_idx), 32'd0);
        check("rst_strobe", {31'd0, step_strobe}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        mon_en = 1'b1;

        // Clear the table so later short programs start from known entries.
        for (int i = 0; i < DEPTH; i++) write_entry(i, 4'h0, 0, 1'b1);

        // Directed three-step program: 4,4,9,2,2,2 then done.
        load_three_step();
        start_play(3);
        wait_drain();

        // len = 0: only a done pulse.
        start_play(0);
        wait_drain();

        // Abort during step 1 (third busy cycle).
        start_play(3);
        abort_after(3);

        // Write and start during playback are ignored; replay shows 0x4.
        start_play(3);
        write_entry(0, 4'hF, 7, 1'b0);
        start = 1'b1;
        len   = (AW+1)'(1);
        tick();
        start = 1'b0;
        wait_drain();
        start_play(3);
        wait_drain();

        // Detector-style program with dwell 0, len 20 clamped to 16.
        write_entry(0, 4'(1 << I3_BIT), 0, 1'b1);
        write_entry(1, 4'((1 << I1_BIT) | (1 << I4_BIT)), 0, 1'b1);
        for (int i = 2; i < DEPTH; i++) write_entry(i, 4'($urandom_range(0, 15)), 0, 1'b1);
        start_play(20);
        wait_drain();

        // Maximum dwell: one step held for 2^DW cycles.
        write_entry(0, 4'hA, (1 << DW) - 1, 1'b1);
        start_play(1);
        wait_drain();

        // Randomized programs.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < DEPTH; i++)
                write_entry(i, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b1);
            start_play(int'($urandom_range(0, DEPTH + 3)));
            wait_drain();
        end

        // Reset in the middle of playback returns everything to idle.
        load_three_step();
        start_play(3);
        tick();
        mon_en = 1'b0;
        reset  = 1'b1;
        tick();
        reset  = 1'b0;
        exp_q.delete();
        check("midrst_vec", {28'd0, vec_out}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_idx", 32'(step_idx), 32'd0);
        mon_en = 1'b1;
        // Table survives reset.
        start_play(3);
        wait_drain();

`ifdef STIM_VEC_PLAYER_LOOP_EN
        loop_test();
`endif

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
